// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader
//   Accepts one instruction as separate fields over a valid/ready handshake,
//   range-checks the immediate for the opcode, and packs the fields into the
//   16-bit ISA word. The word is written to instruction memory at an
//   auto-incrementing byte address, with wait states. Loading stops after HLT.
//
// Ports
//   clk, rst_n          clock, async active-low reset
//   restart             sync return to IDLE, clears address/count/flags
//   op_valid/op_ready   field bundle handshake (ready only in IDLE)
//   op_code/rd/rs/rt/cc/imm  instruction fields
//   mem_wr_en/addr/wdata/ack  instruction-memory write port, held until ack
//   err, err_sticky     range violation pulse / sticky flag
//   wrapped             address wrapped past top of memory
//   done                HLT written
//   instr_count         instructions written (saturating)
//
// state | meaning
// ------+---------------------------------------------------
// IDLE  | ready for a bundle, op_ready=1
// WRITE | write request held on mem_*, waiting for mem_ack
// DONE  | HLT written, only restart or reset leaves
module instr_encoder_loader #(
  parameter int unsigned             ADDR_W    = 16,
  parameter logic [ADDR_W-1:0]       BASE_ADDR = '0,
  parameter int unsigned             ADDR_STEP = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              restart,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [3:0]        op_code,
  input  logic [3:0]        op_rd,
  input  logic [3:0]        op_rs,
  input  logic [3:0]        op_rt,
  input  logic [2:0]        op_cc,
  input  logic [15:0]       op_imm,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic              mem_ack,
  output logic              err,
  output logic              err_sticky,
  output logic              wrapped,
  output logic              done,
  output logic [15:0]       instr_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state;
  logic              is_hlt;
  logic [15:0]       enc_word;
  logic              imm_ok;
  logic [ADDR_W:0]   addr_sum;

  // Field packing and immediate range check. Signed ranges are checked by
  // requiring the bits above the field to be a pure sign extension.
  always_comb begin
    enc_word = 16'h0000;
    imm_ok   = 1'b1;
    case (op_code)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h7: begin
        enc_word = {op_code, op_rd, op_rs, op_rt};
      end
      4'h4, 4'h5, 4'h6: begin
        enc_word = {op_code, op_rd, op_rs, op_imm[3:0]};
        imm_ok   = (op_imm[15:4] == 12'h000);
      end
      4'h8, 4'h9: begin
        enc_word = {op_code, op_rd, op_rs, op_imm[3:0]};
        imm_ok   = (op_imm[15:3] == 13'h0000) || (op_imm[15:3] == 13'h1FFF);
      end
      4'hA, 4'hB: begin
        enc_word = {op_code, op_rd, op_imm[7:0]};
        imm_ok   = (op_imm[15:8] == 8'h00);
      end
      4'hC: begin
        enc_word = {op_code, op_cc, op_imm[8:0]};
        imm_ok   = (op_imm[15:8] == 8'h00) || (op_imm[15:8] == 8'hFF);
      end
      4'hD: begin
        enc_word = {op_code, op_cc, 1'b0, op_rs, 4'h0};
      end
      4'hE: begin
        enc_word = {op_code, op_rd, 8'h00};
      end
      default: begin
        enc_word = 16'hF000;
      end
    endcase
  end

  // One extra bit catches the carry out of the top address.
  assign addr_sum = {1'b0, mem_addr} + (ADDR_W+1)'(ADDR_STEP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      is_hlt      <= 1'b0;
      op_ready    <= 1'b1;
      mem_wr_en   <= 1'b0;
      mem_addr    <= BASE_ADDR;
      mem_wdata   <= 16'h0000;
      err         <= 1'b0;
      err_sticky  <= 1'b0;
      wrapped     <= 1'b0;
      done        <= 1'b0;
      instr_count <= 16'h0000;
    end else begin
      err <= 1'b0;
      if (restart) begin
        // Abandons any pending write; a same-cycle ack is ignored.
        state       <= IDLE;
        is_hlt      <= 1'b0;
        op_ready    <= 1'b1;
        mem_wr_en   <= 1'b0;
        mem_addr    <= BASE_ADDR;
        err_sticky  <= 1'b0;
        wrapped     <= 1'b0;
        done        <= 1'b0;
        instr_count <= 16'h0000;
      end else begin
        case (state)
          IDLE: begin
            if (op_valid) begin
              if (imm_ok) begin
                mem_wdata <= enc_word;
                mem_wr_en <= 1'b1;
                op_ready  <= 1'b0;
                is_hlt    <= (op_code == 4'hF);
                state     <= WRITE;
              end else begin
                err        <= 1'b1;
                err_sticky <= 1'b1;
              end
            end
          end
          WRITE: begin
            if (mem_ack) begin
              mem_wr_en <= 1'b0;
              if (addr_sum[ADDR_W]) begin
                mem_addr <= BASE_ADDR;
                wrapped  <= 1'b1;
              end else begin
                mem_addr <= addr_sum[ADDR_W-1:0];
              end
              if (instr_count != 16'hFFFF) begin
                instr_count <= instr_count + 16'h0001;
              end
              if (is_hlt) begin
                done  <= 1'b1;
                state <= DONE;
              end else begin
                op_ready <= 1'b1;
                state    <= IDLE;
              end
            end
          end
          DONE: begin
            op_ready <= 1'b0;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
